// File: rtl/op_amp_with_frac.sv
// Non-inverting op-amp model: divided core clock, first-order slew toward gain*input, float output.
// Optional build macro OP_AMP_RAIL_CLAMP_EN clamps the target to the output rail.
module op_amp_with_frac #(
  parameter int          DIV     = 1000,
  parameter logic [15:0] GAIN_Q8 = 16'h0200,
  parameter int          SHIFT   = 3,
  parameter logic [15:0] RAIL    = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        clk_100k,
  input  logic [15:0] non_inv,
  output logic [31:0] square_out
);

  localparam int            CW       = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST     = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF     = CW'(DIV / 2);
  localparam logic [40:0]   SNAP_LIM = 41'd1 << SHIFT;

  // Q24.16 -> IEEE-754 single, truncating; leading one at bit p gives exponent 111 + p.
  function automatic logic [31:0] q24_16_to_float(input logic [39:0] v);
    logic [5:0]  p;
    logic [22:0] mant;
    p = 6'd0;
    for (int i = 0; i < 40; i++) begin
      if (v[i]) p = 6'(i);
    end
    mant = 23'((v << (6'd39 - p)) >> 16);
    if (v == 40'd0) return 32'h0000_0000;
    else            return {1'b0, 8'd111 + {2'b00, p}, mant};
  endfunction

  logic [CW-1:0]      count_r;
  logic [CW-1:0]      count_nxt_s;
  logic               core_en_s;
  logic [31:0]        prod_s;
  logic [39:0]        target_raw_s;
  logic [39:0]        target_s;
  logic [39:0]        y_r;
  logic [39:0]        y_nxt_s;
  logic signed [40:0] diff_s;
  logic signed [40:0] step_s;
  logic [40:0]        mag_s;
  logic [31:0]        float_s;

  // Divider next count; the core steps on the clk edge where clk_100k goes high.
  always_comb begin
    count_nxt_s = '0;
    if (count_r == LAST) count_nxt_s = '0;
    else                 count_nxt_s = count_r + CW'(1);
    core_en_s = (count_nxt_s == HALF);
  end

  // Divider counter and registered 50% duty clk_100k.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r  <= '0;
      clk_100k <= 1'b0;
    end else begin
      count_r  <= count_nxt_s;
      clk_100k <= (count_nxt_s >= HALF);
    end
  end

  assign prod_s       = 32'({16'd0, non_inv} * {16'd0, GAIN_Q8});
  assign target_raw_s = {prod_s, 8'd0};

`ifdef OP_AMP_RAIL_CLAMP_EN
  logic [39:0] rail_lim_s;
  assign rail_lim_s = {8'd0, RAIL, 16'd0};
  assign target_s   = (target_raw_s > rail_lim_s) ? rail_lim_s : target_raw_s;
`else
  logic unused_rail_s;
  assign unused_rail_s = ^RAIL;
  assign target_s      = target_raw_s;
`endif

  // Slew step with snap: the final sub-step lands exactly on target so no limit cycle remains.
  always_comb begin
    diff_s  = $signed({1'b0, target_s}) - $signed({1'b0, y_r});
    step_s  = diff_s >>> SHIFT;
    mag_s   = diff_s[40] ? 41'(-diff_s) : 41'(diff_s);
    y_nxt_s = y_r;
    if (mag_s < SNAP_LIM) y_nxt_s = target_s;
    else                  y_nxt_s = 40'({1'b0, y_r} + step_s);
    float_s = q24_16_to_float(y_r);
  end

  // Core state and output, advanced once per clk_100k period; output reflects pre-edge y.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_r        <= 40'd0;
      square_out <= 32'd0;
    end else if (core_en_s) begin
      y_r        <= y_nxt_s;
      square_out <= float_s;
    end
  end

endmodule

// File: tb/tb_op_amp_with_frac.sv
// Directed bench for op_amp_with_frac with a short divider (DIV=8) to keep runtimes small.
module tb_op_amp_with_frac;

  localparam int DIV = 8;

  logic        clk;
  logic        reset_n;
  logic        clk_100k;
  logic [15:0] non_inv;
  logic [31:0] square_out;

  int  n_chk;
  int  n_pass;
  bit  clk_dead;

  op_amp_with_frac #(.DIV(DIV)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clk_100k   (clk_100k),
    .non_inv    (non_inv),
    .square_out (square_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait for the next rising clk_100k, returning 1 ns after that clk edge.
  task automatic core_edge();
    logic prev;
    int   n;
    if (clk_dead) return;
    prev = clk_100k;
    n    = 0;
    forever begin
      @(posedge clk);
      #1;
      if (clk_100k && !prev) return;
      prev = clk_100k;
      n++;
      if (n > 4 * DIV) begin
        n_chk++;
        $display("FAIL core_edge_timeout: clk_100k rise not seen within %0d clk cycles, required one", 4 * DIV);
        clk_dead = 1'b1;
        return;
      end
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) core_edge();
  endtask

  task automatic do_reset(input logic [15:0] v);
    @(negedge clk);
    reset_n = 1'b0;
    non_inv = v;
    #23;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (clk_100k !== 1'b0) $display("FAIL reset_clk: got %b want 0", clk_100k);
    else n_pass++;
    n_chk++;
    if (square_out !== 32'h0) $display("FAIL reset_out: got %h want 00000000", square_out);
    else n_pass++;
    wait ($time >= 100);
    reset_n = 1'b1;
  endtask

  task automatic test_trajectory();
    logic [31:0] exp_v [3];
    exp_v[0] = 32'h0000_0000;
    exp_v[1] = 32'h4416_0000;
    exp_v[2] = 32'h448C_A000;
    for (int i = 0; i < 3; i++) begin
      core_edge();
      n_chk++;
      if (square_out !== exp_v[i]) $display("FAIL trajectory_%0d: got %h want %h", i, square_out, exp_v[i]);
      else n_pass++;
    end
  endtask

  task automatic test_clock();
    time t0, t1;
    int  hi;
    core_edge();
    t0 = $time;
    hi = 0;
    while (clk_100k === 1'b1 && hi < 4 * DIV) begin
      @(posedge clk);
      #1;
      hi++;
    end
    core_edge();
    t1 = $time;
    n_chk++;
    if (t1 - t0 !== 80) $display("FAIL clk_period: got %0t want 80", t1 - t0);
    else n_pass++;
    n_chk++;
    if (hi !== DIV / 2) $display("FAIL clk_high: got %0d want %0d clk cycles", hi, DIV / 2);
    else n_pass++;
  endtask

  task automatic test_settle_2400();
    logic [31:0] held;
    bit          stable;
    run_cycles(400);
    n_chk++;
    if (square_out !== 32'h4596_0000) $display("FAIL settle_2400: got %h want 45960000", square_out);
    else n_pass++;
    held   = square_out;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      core_edge();
      if (square_out !== held) stable = 1'b0;
    end
    n_chk++;
    if (!stable) $display("FAIL hold_2400: got %h want 45960000 held", square_out);
    else n_pass++;
  endtask

  task automatic test_step_down();
    logic [31:0] prev;
    bit          mono;
    non_inv = 16'd100;
    prev    = square_out;
    mono    = 1'b1;
    for (int i = 0; i < 200; i++) begin
      core_edge();
      if (square_out > prev) mono = 1'b0;
      prev = square_out;
    end
    n_chk++;
    if (!mono) $display("FAIL step_monotonic: got rise to %h want nonincreasing", square_out);
    else n_pass++;
    n_chk++;
    if (square_out !== 32'h4348_0000) $display("FAIL step_settle: got %h want 43480000", square_out);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    do_reset(16'd2400);
    run_cycles(5);
    #2;
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (clk_100k !== 1'b0 || square_out !== 32'h0)
      $display("FAIL mid_reset: got clk=%b out=%h want 0/00000000", clk_100k, square_out);
    else n_pass++;
    #20;
    reset_n = 1'b1;
    run_cycles(300);
    n_chk++;
    if (square_out !== 32'h4596_0000) $display("FAIL mid_reset_reconverge: got %h want 45960000", square_out);
    else n_pass++;
  endtask

  task automatic test_zero_one();
    bit all_zero;
    do_reset(16'd0);
    all_zero = 1'b1;
    for (int i = 0; i < 30; i++) begin
      core_edge();
      if (square_out !== 32'h0) all_zero = 1'b0;
    end
    n_chk++;
    if (!all_zero) $display("FAIL zero_input: got %h want 00000000 every cycle", square_out);
    else n_pass++;
    non_inv = 16'd1;
    run_cycles(200);
    n_chk++;
    if (square_out !== 32'h4000_0000) $display("FAIL one_input: got %h want 40000000", square_out);
    else n_pass++;
  endtask

  task automatic test_large();
    logic [31:0] want;
`ifdef OP_AMP_RAIL_CLAMP_EN
    want = 32'h477F_FF00;
`else
    want = 32'h479C_4000;
`endif
    do_reset(16'd40000);
    run_cycles(210);
    n_chk++;
    if (square_out !== want) $display("FAIL large_40000: got %h want %h", square_out, want);
    else n_pass++;
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    clk_dead = 1'b0;
    reset_n  = 1'b0;
    non_inv  = 16'd2400;
    test_reset();
    test_trajectory();
    test_clock();
    test_settle_2400();
    test_step_down();
    test_mid_reset();
    test_zero_one();
    test_large();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
